ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the single-cycle decode/control logic.
- Holds the PC and fetches one instruction word from a wait-state instruction memory.
- Presents the instruction and its decode fields (opcode, func, rt, imm16, index26) to control.
- Computes the next PC from the 2-bit PCsrc that control returns.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset (word aligned).
AW, 32, PC/address width in bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  AW  word address of the request; equals pc.
imem_ack  in  1  memory has returned data this cycle.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
instr  out  32  latched instruction register (IR).
opcode  out  6  IR[31:26].
func  out  6  IR[5:0].
rt  out  5  IR[20:16].
instr_valid  out  1  IR holds a fetched instruction for the current pc.
pc  out  AW  address of the instruction in IR.
pc_plus4  out  AW  pc+4; link value for jal.
advance  in  1  decode/execute has committed the instruction; take next PC.
pcsrc  in  2  00 sequential, 01 taken branch, 10 jal target, 11 jr register.
jr_target  in  AW  register value for jr.
fetch_err  out  1  sticky misaligned-target error (feature-dependent).

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, state=S_BOOT.
- FSM states and transitions:
  - S_BOOT: imem_req=0; unconditionally goes to S_FETCH next cycle.
  - S_FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1, go to S_HOLD. Otherwise remain; addr and req stay stable until ack.
  - S_HOLD: imem_req=0, instr_valid=1. On advance: pc<=next_pc, instr_valid<=0, go to S_FETCH. Otherwise hold IR and pc.
  - S_ERR: only exists with the feature enabled; see Optional Feature.
- Latency: zero-wait memory (ack asserted in the first S_FETCH cycle) gives one instruction per 2 cycles; each extra wait cycle adds one.
- next_pc, all arithmetic modulo 2^AW:
  - 00: pc+4.
  - 01: pc+4 + (sign-extended imm16 << 2).
  - 10: {pc_plus4[31:28], index26, 2'b00}.
  - 11: jr_target.
- Ignored inputs:
  - advance outside S_HOLD has no effect.
  - imem_ack outside S_FETCH has no effect.
  - pcsrc and jr_target are sampled only in the advance cycle.
- Wrap-around: pc=32'hFFFF_FFFC with pcsrc=00 gives next pc 0; no error is raised.
- Reset mid-fetch: the outstanding request is abandoned and a late ack is ignored, because state is S_BOOT.
- opcode, func and rt are pure slices of IR. They are valid only while instr_valid=1 and must not be used otherwise.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - When advance fires with pcsrc=11 and jr_target[1:0]!=0, fetch_err<=1 (sticky until reset), pc<=jr_target, state goes to S_ERR.
  - S_ERR: imem_req=0, instr_valid=0, advance ignored; exited only by reset.
- Undefined:
  - jr_target[1:0] are forced to 00 before loading pc.
  - fetch_err is tied to 0 and S_ERR is never entered.

Decomposition:
- Shared package mips_pkg holds:
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JAL=2'b10, PCSRC_JR=2'b11.
  - The fetch-state enum (S_BOOT, S_FETCH, S_HOLD, S_ERR).
  - RESET_PC_DEFAULT.
- One sub-module, ifu_next_pc: purely combinational next_pc computation from pc, IR and pcsrc. It is separately unit-testable.

Test Plan:
- Reset release, ack held high: first request at 0x3000; instr_valid rises on the 2nd cycle after S_BOOT; pc_plus4=0x3004.
- advance with pcsrc=01, imm16=16'hFFFE at pc=0x3010 -> next request at 0x300C.
- advance with pcsrc=10, index26=26'h0000C10 at pc=0x3000 -> next request at 0x00003040; pc_plus4 at the advance cycle = 0x3004.
- imem_ack delayed 3 cycles -> imem_req and addr stable throughout; IR captured only on the ack cycle; advance during the wait is ignored.
- rst_n pulsed low while in S_FETCH, ack arrives during reset -> pc=0x3000, instr_valid=0, ack discarded.
- pcsrc=11, jr_target=0x3006:
  - With IFU_MISALIGN_TRAP_EN: fetch_err=1 and no further imem_req.
  - Without it: next request at 0x3004.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: PC-source encodings, fetch FSM states
// and the default reset vector used by ifu_fetch and ifu_next_pc.
package mips_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JAL = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_FETCH = 2'b01,
        S_HOLD  = 2'b10,
        S_ERR   = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selection from pc, the IR index field and pcsrc.
// Honours IFU_MISALIGN_TRAP_EN: when undefined, jr targets are word-aligned here.
import mips_pkg::*;

module ifu_next_pc #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] pc,
    input  logic [25:0]   instr_index,
    input  logic [1:0]    pcsrc,
    input  logic [AW-1:0] jr_target,
    output logic [AW-1:0] pc_plus4,
    output logic [AW-1:0] next_pc
);

    logic [15:0]   imm16;
    logic [AW-1:0] branch_offset;
    logic [AW-1:0] jal_target;
    logic [AW-1:0] jr_pc;

    assign imm16         = instr_index[15:0];
    assign pc_plus4      = pc + AW'(4);
    assign branch_offset = {{(AW-18){imm16[15]}}, imm16, 2'b00};
    assign jal_target    = {pc_plus4[AW-1:28], instr_index, 2'b00};

`ifdef IFU_MISALIGN_TRAP_EN
    // The raw target is kept so a misaligned jr lands in pc alongside the trap.
    assign jr_pc = jr_target;
`else
    localparam logic [AW-1:0] JR_MASK = {{(AW-2){1'b1}}, 2'b00};
    assign jr_pc = jr_target & JR_MASK;
`endif

    always_comb begin
        next_pc = pc_plus4;
        case (pcsrc)
            PCSRC_SEQ: next_pc = pc_plus4;
            PCSRC_BR:  next_pc = pc_plus4 + branch_offset;
            PCSRC_JAL: next_pc = jal_target;
            PCSRC_JR:  next_pc = jr_pc;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC register, IR and wait-state memory handshake FSM.
// Optional misaligned-jr trap (sticky fetch_err, S_ERR) via IFU_MISALIGN_TRAP_EN.
import mips_pkg::*;

module ifu_fetch #(
    parameter int          AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   instr,
    output logic [5:0]    opcode,
    output logic [5:0]    func,
    output logic [4:0]    rt,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    input  logic          advance,
    input  logic [1:0]    pcsrc,
    input  logic [AW-1:0] jr_target,
    output logic          fetch_err
);

    fetch_state_t  state, state_next;
    logic [AW-1:0] next_pc;
    logic          ir_load;
    logic          pc_load;
    logic          err_set;

    ifu_next_pc #(.AW(AW)) u_next_pc (
        .pc          (pc),
        .instr_index (instr[25:0]),
        .pcsrc       (pcsrc),
        .jr_target   (jr_target),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc)
    );

    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_BOOT:  state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    pc_load    = 1'b1;
                    state_next = S_FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
                    if (pcsrc == PCSRC_JR && jr_target[1:0] != 2'b00) begin
                        err_set    = 1'b1;
                        state_next = S_ERR;
                    end
`endif
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
            pc    <= RESET_PC;
            instr <= 32'h0;
        end else begin
            state <= state_next;
            if (pc_load) pc <= next_pc;
            if (ir_load) instr <= imem_rdata;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    logic fetch_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       fetch_err_q <= 1'b0;
        else if (err_set) fetch_err_q <= 1'b1;
    end

    assign fetch_err = fetch_err_q;
`else
    logic unused_err;
    assign unused_err = err_set;
    assign fetch_err  = 1'b0;
`endif

    // IR contents are only meaningful while parked in S_HOLD.
    assign instr_valid = (state == S_HOLD);
    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign opcode      = instr[31:26];
    assign func        = instr[5:0];
    assign rt          = instr[20:16];

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch: handshake timing, next-PC modes,
// wait states, reset mid-fetch and the misaligned jr case (IFU_MISALIGN_TRAP_EN aware).
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rt;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic [1:0]  pcsrc;
    logic [31:0] jr_target;
    logic        fetch_err;

    int tests_run = 0;
    int tests_failed = 0;

    ifu_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .func        (func),
        .rt          (rt),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .advance     (advance),
        .pcsrc       (pcsrc),
        .jr_target   (jr_target),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic ack, input logic [31:0] rdata,
                                  input logic adv, input logic [1:0] src,
                                  input logic [31:0] jr);
        imem_ack   = ack;
        imem_rdata = rdata;
        advance    = adv;
        pcsrc      = src;
        jr_target  = jr;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_pc", pc, 32'h0000_3000);
        check_output("rst_valid", 32'(instr_valid), 32'h0);
        check_output("rst_req", 32'(imem_req), 32'h0);
        check_output("rst_instr", instr, 32'h0);
        check_output("rst_err", 32'(fetch_err), 32'h0);

        // Boot with ack held high: j 0x0000C10 fetched at 0x3000
        rst_n = 1'b1;
        apply_stimulus(1'b1, 32'h0800_0C10, 1'b0, 2'b00, 32'h0);
        tick();
        check_output("boot_req", 32'(imem_req), 32'h1);
        check_output("boot_addr", imem_addr, 32'h0000_3000);
        check_output("boot_valid0", 32'(instr_valid), 32'h0);
        tick();
        check_output("boot_valid1", 32'(instr_valid), 32'h1);
        check_output("boot_instr", instr, 32'h0800_0C10);
        check_output("boot_opcode", 32'(opcode), 32'h2);
        check_output("boot_pc4", pc_plus4, 32'h0000_3004);
        check_output("hold_req", 32'(imem_req), 32'h0);

        // jal at 0x3000
        apply_stimulus(1'b0, 32'h0, 1'b1, 2'b10, 32'h0);
        check_output("jal_pc4", pc_plus4, 32'h0000_3004);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        check_output("jal_addr", imem_addr, 32'h0000_3040);
        check_output("jal_req", 32'(imem_req), 32'h1);
        check_output("jal_valid", 32'(instr_valid), 32'h0);

        // jr to 0x3010 to set up the branch
        apply_stimulus(1'b1, 32'h03E0_0008, 1'b0, 2'b00, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1, 2'b11, 32'h0000_3010);
        tick();
        check_output("jr_addr", imem_addr, 32'h0000_3010);

        // beq with imm16 = 0xFFFE at 0x3010 -> 0x3014 - 8 = 0x300C
        apply_stimulus(1'b1, 32'h1000_FFFE, 1'b0, 2'b00, 32'h0);
        tick();
        check_output("br_opcode", 32'(opcode), 32'h4);
        check_output("br_func", 32'(func), 32'h3E);
        check_output("br_rt", 32'(rt), 32'h0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 2'b01, 32'h0);
        tick();
        check_output("br_addr", imem_addr, 32'h0000_300C);
        check_output("br_req", 32'(imem_req), 32'h1);

        // Three wait cycles with advance asserted (must be ignored)
        apply_stimulus(1'b0, 32'hFFFF_FFFF, 1'b1, 2'b10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("wait%0d_req", i), 32'(imem_req), 32'h1);
            check_output($sformatf("wait%0d_addr", i), imem_addr, 32'h0000_300C);
            check_output($sformatf("wait%0d_instr", i), instr, 32'h1000_FFFE);
        end
        apply_stimulus(1'b1, 32'h8C43_0008, 1'b0, 2'b00, 32'h0);
        tick();
        check_output("lw_instr", instr, 32'h8C43_0008);
        check_output("lw_opcode", 32'(opcode), 32'h23);
        check_output("lw_rt", 32'(rt), 32'h3);
        check_output("lw_func", 32'(func), 32'h8);
        check_output("lw_pc", pc, 32'h0000_300C);

        // ack outside S_FETCH is ignored
        apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0);
        tick();
        check_output("late_ack_instr", instr, 32'h8C43_0008);
        check_output("late_ack_valid", 32'(instr_valid), 32'h1);

        // Wrap-around from 0xFFFFFFFC
        apply_stimulus(1'b0, 32'h0, 1'b1, 2'b11, 32'hFFFF_FFFC);
        tick();
        check_output("wrap_setup", imem_addr, 32'hFFFF_FFFC);
        apply_stimulus(1'b1, 32'h0, 1'b0, 2'b00, 32'h0);
        tick();
        check_output("wrap_pc4", pc_plus4, 32'h0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 2'b00, 32'h0);
        tick();
        check_output("wrap_addr", imem_addr, 32'h0);
        check_output("wrap_err", 32'(fetch_err), 32'h0);

        // Reset asserted mid-fetch; ack arrives while reset is held
        apply_stimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_pc", pc, 32'h0000_3000);
        check_output("midrst_req", 32'(imem_req), 32'h0);
        apply_stimulus(1'b1, 32'h1234_5678, 1'b0, 2'b00, 32'h0);
        tick();
        check_output("midrst_instr", instr, 32'h0);
        check_output("midrst_valid", 32'(instr_valid), 32'h0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        rst_n = 1'b1;
        tick();
        check_output("rerun_addr", imem_addr, 32'h0000_3000);
        check_output("rerun_req", 32'(imem_req), 32'h1);

        // Misaligned jr target 0x3006
        apply_stimulus(1'b1, 32'h03E0_0008, 1'b0, 2'b00, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1, 2'b11, 32'h0000_3006);
        tick();
`ifdef IFU_MISALIGN_TRAP_EN
        check_output("trap_err", 32'(fetch_err), 32'h1);
        check_output("trap_req", 32'(imem_req), 32'h0);
        check_output("trap_valid", 32'(instr_valid), 32'h0);
        check_output("trap_pc", pc, 32'h0000_3006);
        repeat (2) tick();
        check_output("trap_sticky", 32'(fetch_err), 32'h1);
        check_output("trap_req2", 32'(imem_req), 32'h0);
`else
        check_output("jr_mask_addr", imem_addr, 32'h0000_3004);
        check_output("jr_mask_req", 32'(imem_req), 32'h1);
        check_output("jr_mask_err", 32'(fetch_err), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
